// File: rtl/id_stage.sv
// id_stage: registered instruction decode feeding a DEPTH-entry output queue.
// A RUN/HALTED FSM stops intake after a halt word until flush.
// Optional macro ID_BPRED_EN adds a 2-bit saturating branch history table;
// without it only unconditional branches are predicted taken.
//
// state  | meaning
// RUN    | accepting fetch words while the queue has room
// HALTED | halt word accepted; intake stopped until flush
module id_stage #(
    parameter int DEPTH     = 2,
    parameter int PC_W      = 32,
    parameter int BHT_IDX_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [1:0]      out_class,
    output logic            out_setf,
    output logic [3:0]      out_op,
    output logic [3:0]      out_cond,
    output logic [2:0]      out_rd,
    output logic [2:0]      out_rs1,
    output logic [2:0]      out_rs2,
    output logic [15:0]     out_imm,
    output logic [PC_W-1:0] out_pc,
    output logic [6:0]      out_flags,
    output logic            out_pred_taken,
    input  logic            flush,
    output logic            halted,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {RUN, HALTED} state_t;

    typedef struct packed {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
        logic [6:0]      flags;
        logic            pred;
    } entry_t;

    state_t            state_q, state_d;
    entry_t            mem_q [DEPTH];
    entry_t            mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [6:0]        dec_flags;
    logic              dec_pred, is_ubr, is_cbr, push, pop, full;
    entry_t            head;

    // Decode flags {illegal, halt, nop, br_reg, br, st, ld} from the incoming word
    always_comb begin
        dec_flags = '0;
        case (in_instr[31:30])
            2'b00: begin
                case (in_instr[29:25])
                    5'b00000, 5'b00001, 5'b10001, 5'b11001, 5'b10010, 5'b11010,
                    5'b10011, 5'b11011, 5'b10100, 5'b11100, 5'b10101, 5'b11101,
                    5'b00100, 5'b00101, 5'b00010, 5'b00011: dec_flags[6] = 1'b0;
                    default:                                dec_flags[6] = 1'b1;
                endcase
            end
            2'b01: begin
                case (in_instr[29:25])
                    5'b10001, 5'b11001, 5'b10010, 5'b11010, 5'b10011, 5'b11011,
                    5'b10100, 5'b11100, 5'b10101, 5'b11101, 5'b10110: dec_flags[6] = 1'b0;
                    default:                                           dec_flags[6] = 1'b1;
                endcase
            end
            2'b10: begin
                dec_flags[1] = in_instr[25];
                dec_flags[0] = ~in_instr[25];
            end
            default: begin
                case (in_instr[28:25])
                    4'b0000, 4'b0001: dec_flags[2] = 1'b1;
                    4'b0010:          dec_flags[3] = 1'b1;
                    default: begin
                        if (in_instr[27])      dec_flags[4] = 1'b1;
                        else if (in_instr[28]) dec_flags[5] = 1'b1;
                        else                   dec_flags[6] = 1'b1;
                    end
                endcase
            end
        endcase
    end

    assign is_ubr = (in_instr[31:30] == 2'b11) && (in_instr[28:25] == 4'b0000);
    assign is_cbr = (in_instr[31:30] == 2'b11) && (in_instr[28:25] == 4'b0001);

`ifdef ID_BPRED_EN
    localparam int BHT_N = 2 ** BHT_IDX_W;
    logic [1:0]           bht_q [BHT_N];
    logic [1:0]           bht_d [BHT_N];
    logic [BHT_IDX_W-1:0] upd_idx;
    logic                 unused_upd_pc;

    assign upd_idx       = upd_pc[BHT_IDX_W+1:2];
    assign unused_upd_pc = ^upd_pc;
    // Lookup reads the registered table, so a same-cycle update is not visible
    assign dec_pred = is_ubr | (is_cbr & bht_q[in_pc[BHT_IDX_W+1:2]][1]);

    // Saturating counter update from branch resolution
    always_comb begin
        bht_d = bht_q;
        if (upd_valid) begin
            if (upd_taken && bht_q[upd_idx] != 2'b11)
                bht_d[upd_idx] = bht_q[upd_idx] + 2'b01;
            else if (!upd_taken && bht_q[upd_idx] != 2'b00)
                bht_d[upd_idx] = bht_q[upd_idx] - 2'b01;
        end
    end

    // Counters start weakly not-taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
        end else begin
            bht_q <= bht_d;
        end
    end
`else
    logic unused_upd;

    assign unused_upd = ^{upd_valid, upd_pc, upd_taken, is_cbr};
    assign dec_pred   = is_ubr;
`endif

    assign full      = (count_q == CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign halted    = (state_q == HALTED);
    assign in_ready  = ~full & ~halted & ~flush;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Queue next-state; flush empties it and overrides any push or pop
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{instr: in_instr, pc: in_pc, flags: dec_flags, pred: dec_pred};
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Halt word stops intake once accepted; only flush resumes
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (push && dec_flags[5]) state_d = HALTED;
            HALTED:  if (flush)                state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Queue storage is cleared on reset so idle outputs read as zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= RUN;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
        end
    end

    assign head           = mem_q[rd_ptr_q];
    assign out_class      = head.instr[31:30];
    assign out_setf       = head.instr[29];
    assign out_op         = head.instr[28:25];
    assign out_cond       = head.instr[24:21];
    assign out_rd         = head.instr[24:22];
    assign out_rs1        = head.instr[21:19];
    assign out_rs2        = head.instr[18:16];
    assign out_imm        = head.instr[15:0];
    assign out_pc         = head.pc;
    assign out_flags      = head.flags;
    assign out_pred_taken = head.pred;
endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: expected entries are queued when a word is
// accepted and compared field by field when the head is consumed.
module tb_id_stage;
    localparam int DEPTH     = 4;
    localparam int PC_W      = 32;
    localparam int BHT_IDX_W = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0, in_ready;
    logic [31:0]     in_instr = '0;
    logic [PC_W-1:0] in_pc = '0;
    logic            out_valid, out_ready = 1'b0;
    logic [1:0]      out_class;
    logic            out_setf;
    logic [3:0]      out_op, out_cond;
    logic [2:0]      out_rd, out_rs1, out_rs2;
    logic [15:0]     out_imm;
    logic [PC_W-1:0] out_pc;
    logic [6:0]      out_flags;
    logic            out_pred_taken;
    logic            flush = 1'b0, halted;
    logic            upd_valid = 1'b0, upd_taken = 1'b0;
    logic [PC_W-1:0] upd_pc = '0;

    id_stage #(.DEPTH(DEPTH), .PC_W(PC_W), .BHT_IDX_W(BHT_IDX_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_setf(out_setf), .out_op(out_op), .out_cond(out_cond),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
        .out_pc(out_pc), .out_flags(out_flags), .out_pred_taken(out_pred_taken),
        .flush(flush), .halted(halted),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
        logic            pred;
    } exp_t;

    exp_t       exp_q[$];
    logic       m_halted = 1'b0;
    logic [1:0] m_bht [2**BHT_IDX_W];
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decode: {illegal, halt, nop, br_reg, br, st, ld}
    function automatic logic [6:0] ref_flags(input logic [31:0] w);
        logic [4:0] f;
        logic [3:0] op;
        f  = w[29:25];
        op = w[28:25];
        ref_flags = 7'd0;
        if (w[31:30] == 2'b00) begin
            if (!(f inside {5'b00000, 5'b00001, 5'b10001, 5'b11001, 5'b10010, 5'b11010, 5'b10011, 5'b11011,
                            5'b10100, 5'b11100, 5'b10101, 5'b11101, 5'b00100, 5'b00101, 5'b00010, 5'b00011}))
                ref_flags = 7'b1000000;
        end else if (w[31:30] == 2'b01) begin
            if (!(f inside {5'b10001, 5'b11001, 5'b10010, 5'b11010, 5'b10011, 5'b11011,
                            5'b10100, 5'b11100, 5'b10101, 5'b11101, 5'b10110}))
                ref_flags = 7'b1000000;
        end else if (w[31:30] == 2'b10) begin
            ref_flags = w[25] ? 7'b0000010 : 7'b0000001;
        end else begin
            if (op == 4'd0 || op == 4'd1) ref_flags = 7'b0000100;
            else if (op == 4'd2)          ref_flags = 7'b0001000;
            else if (w[27])               ref_flags = 7'b0010000;
            else if (w[28])               ref_flags = 7'b0100000;
            else                          ref_flags = 7'b1000000;
        end
    endfunction

    function automatic logic ref_pred(input logic [31:0] w, input logic [PC_W-1:0] pc);
        ref_pred = 1'b0;
        if (w[31:30] == 2'b11 && w[28:25] == 4'd0) ref_pred = 1'b1;
`ifdef ID_BPRED_EN
        if (w[31:30] == 2'b11 && w[28:25] == 4'd1) ref_pred = m_bht[pc[BHT_IDX_W+1:2]][1];
`else
        if (pc == '1) ref_pred = ref_pred;
`endif
    endfunction

    task automatic bht_reset();
        for (int i = 0; i < 2**BHT_IDX_W; i++) m_bht[i] = 2'b01;
    endtask

    // One cycle: drive at negedge, check just after, update model for the coming edge
    task automatic step(input logic v, input logic [31:0] w, input logic [PC_W-1:0] pc,
                        input logic rdy, input logic fl,
                        input logic uv, input logic [PC_W-1:0] upc, input logic ut);
        logic acc;
        exp_t e, h;
        @(negedge clk);
        in_valid = v; in_instr = w; in_pc = pc; out_ready = rdy; flush = fl;
        upd_valid = uv; upd_pc = upc; upd_taken = ut;
        #1;
        acc = v && (exp_q.size() < DEPTH) && !m_halted && !fl;
        check_eq("out_valid", out_valid, exp_q.size() != 0);
        check_eq("in_ready", in_ready, (exp_q.size() < DEPTH) && !m_halted && !fl);
        check_eq("halted", halted, m_halted);
        if (exp_q.size() != 0 && rdy && !fl) begin
            h = exp_q.pop_front();
            check_eq("class", out_class, h.instr[31:30]);
            check_eq("setf", out_setf, h.instr[29]);
            check_eq("op", out_op, h.instr[28:25]);
            check_eq("cond", out_cond, h.instr[24:21]);
            check_eq("rd", out_rd, h.instr[24:22]);
            check_eq("rs1", out_rs1, h.instr[21:19]);
            check_eq("rs2", out_rs2, h.instr[18:16]);
            check_eq("imm", out_imm, h.instr[15:0]);
            check_eq("pc", out_pc, h.pc);
            check_eq("flags", out_flags, ref_flags(h.instr));
            check_eq("pred", out_pred_taken, h.pred);
        end
        if (acc) begin
            e.instr = w; e.pc = pc; e.pred = ref_pred(w, pc);
            exp_q.push_back(e);
            if (ref_flags(w)[5]) m_halted = 1'b1;
        end
        if (fl) begin
            exp_q.delete();
            m_halted = 1'b0;
        end
`ifdef ID_BPRED_EN
        if (uv) begin
            if (ut && m_bht[upc[BHT_IDX_W+1:2]] != 2'b11)
                m_bht[upc[BHT_IDX_W+1:2]] = m_bht[upc[BHT_IDX_W+1:2]] + 2'b01;
            else if (!ut && m_bht[upc[BHT_IDX_W+1:2]] != 2'b00)
                m_bht[upc[BHT_IDX_W+1:2]] = m_bht[upc[BHT_IDX_W+1:2]] - 2'b01;
        end
`endif
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'd0, '0, rdy, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic push(input logic [31:0] w, input logic [PC_W-1:0] pc, input logic rdy);
        step(1'b1, w, pc, rdy, 1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        bht_reset();
        #2;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_halted", halted, 1'b0);
        check_eq("rst_flags", out_flags, 7'd0);
        check_eq("rst_pc", out_pc, '0);
        check_eq("rst_imm", out_imm, 16'd0);
        check_eq("rst_pred", out_pred_taken, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Field extraction on a known word
        idle(1'b0);
        push(32'h22500005, 32'h100, 1'b0);
        idle(1'b0);
        check_eq("v_class", out_class, 2'b00);
        check_eq("v_op", out_op, 4'b0001);
        check_eq("v_setf", out_setf, 1'b1);
        check_eq("v_rd", out_rd, 3'd1);
        check_eq("v_rs1", out_rs1, 3'd2);
        check_eq("v_imm", out_imm, 16'h0005);
        check_eq("v_flags", out_flags, 7'd0);
        check_eq("v_pc", out_pc, 32'h100);
        idle(1'b1);
        idle(1'b1);

        // Fill to full with consumer stalled, then release one slot
        for (int i = 0; i < DEPTH + 1; i++) push(32'h80000000 | i, 32'h200 + 4 * i, 1'b0);
        check_eq("full_in_ready", in_ready, 1'b0);
        idle(1'b1);
        idle(1'b0);
        check_eq("slot_in_ready", in_ready, 1'b1);
        push(32'h82000077, 32'h300, 1'b1);
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);

        // Halt: intake stops, entry delivered, flush resumes
        push(32'hF0000000, 32'h400, 1'b0);
        idle(1'b0);
        check_eq("halt_flag", out_flags[5], 1'b1);
        check_eq("halt_state", halted, 1'b1);
        push(32'h80000001, 32'h404, 1'b0);
        idle(1'b1);
        step(1'b1, 32'h80000002, 32'h408, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        idle(1'b1);
        check_eq("post_flush_ready", in_ready, 1'b1);

        // Flush with entries queued plus a same-cycle push
        push(32'h80000010, 32'h500, 1'b0);
        push(32'h80000011, 32'h504, 1'b0);
        step(1'b1, 32'h80000012, 32'h508, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        idle(1'b1);
        check_eq("flush_empty", out_valid, 1'b0);

        // nop and illegal decode
        push(32'hC8000000, 32'h600, 1'b1);
        push(32'h3E000000, 32'h604, 1'b1);
        idle(1'b0);
        check_eq("illegal_flag", out_flags[6], 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Branch prediction after two taken updates at pc 0x40
        step(1'b0, 32'd0, '0, 1'b1, 1'b0, 1'b1, 32'h40, 1'b1);
        step(1'b0, 32'd0, '0, 1'b1, 1'b0, 1'b1, 32'h40, 1'b1);
        push(32'hC2000010, 32'h40, 1'b1);
        push(32'hC0000000, 32'h44, 1'b1);
        push(32'hC4000000, 32'h48, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 32'($urandom_range(0, 255)) << 2,
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 2, 1'($urandom_range(0, 1)));
        end
        step(1'b0, 32'd0, '0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        idle(1'b1);

        // Asynchronous reset with two entries queued
        push(32'h80000020, 32'h700, 1'b0);
        push(32'h80000021, 32'h704, 1'b0);
        idle(1'b0);
        check_eq("pre_rst_valid", out_valid, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; upd_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("arst_valid", out_valid, 1'b0);
        check_eq("arst_pc", out_pc, '0);
        check_eq("arst_flags", out_flags, 7'd0);
        check_eq("arst_halted", halted, 1'b0);
        exp_q.delete();
        m_halted = 1'b0;
        bht_reset();
        @(negedge clk);
        rst = 1'b0;
        idle(1'b0);
        check_eq("rel_in_ready", in_ready, 1'b1);
        push(32'hC2000000, 32'h40, 1'b1);
        idle(1'b1);
        idle(1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
